pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline stage register that replaces fixed-function stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque WIDTH-bit payload (packed PC, instruction, decoded fields, control word, operands) under a valid/ready handshake. An optional skid entry registers the ready path. Squash is configurable to hold an in-flight stalled memory-stage entry until the data cache accepts it.

Parameters:
WIDTH, 256, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
HOLD_ON_STALL, 0, 1 = squash retains main entry while out_valid & ~out_ready (EX/MEM use)
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept beat this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts main entry
out_data  out  WIDTH  main entry payload
squash  in  1  kill stored entries (branch mispredict / flush)
occupancy  out  2  valid entries held (0..2)
drop_cnt  out  CNT_W  saturating count of stored valid entries discarded by squash

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=1 at posedge): main/skid valid=0, main/skid data=0, drop_cnt=0. in_ready forced 0 while rst is high. out_valid=0, out_data=0, occupancy=0 after reset.
- Latency: accepted beat appears on out_data the next cycle (1 cycle). Zero-bubble throughput at 1 beat/cycle when out_ready=1.
- Invalid entries always hold all-zero data (bubble = NOP control word).
- SKID=1 states, encoded by occupancy:
  EMPTY(0): in_fire -> main<=in_data, ONE.
  ONE(1): in_fire&out_fire -> main<=in_data, stay ONE. in_fire&~out_fire -> skid<=in_data, TWO. ~in_fire&out_fire -> main cleared, EMPTY.
  TWO(2): out_fire -> main<=skid, skid cleared, ONE. Otherwise hold.
  in_ready = ~rst & (occupancy != 2). It is a function of registered state only.
- SKID=0: single main entry. in_ready = ~rst & (~out_valid | out_ready). Transitions follow EMPTY/ONE above. The ONE -> TWO transition cannot occur. occupancy is 0 or 1.
- Squash has priority over all transitions. The input beat presented in the squash cycle is dropped (in_ready still reflects state; no entry is created).
  HOLD_ON_STALL=0: main and skid are cleared and zeroed. Next state is EMPTY.
  HOLD_ON_STALL=1: if out_valid & ~out_ready, main is held unchanged, skid is cleared, and next state is ONE. Otherwise behaves as HOLD_ON_STALL=0. A held entry drains normally on a later out_fire.
  An entry completing out_fire in the squash cycle is delivered, not counted as dropped.
- drop_cnt increments by the number of valid stored entries discarded in the squash cycle (0, 1 or 2). It excludes the entry delivered by out_fire, the held entry and the input beat. It saturates at 2^CNT_W-1 and does not wrap.
- Squash with rst: rst wins.
- Squash while EMPTY: no-op, drop_cnt unchanged.
- out_data and out_valid are driven directly from the main register (no combinational path from in_* to out_*).

Test Plan:
1. Streaming: SKID=1, out_ready=1, in_data=1..8 on consecutive cycles -> out_data 1..8 on cycles 2..9, out_valid continuous, occupancy=1, in_ready=1 throughout.
2. Backpressure: SKID=1, out_ready=0 and beats 0xA, 0xB -> occupancy=2, in_ready=0, 0xC held upstream. out_ready=1 -> outputs 0xA, 0xB, 0xC in order, nothing lost or duplicated.
3. Squash, HOLD_ON_STALL=0, occupancy=2 with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0, drop_cnt=2, input beat absent from output.
4. Squash, HOLD_ON_STALL=1, main=0x55 valid, out_ready=0, skid=0x66 -> main stays 0x55, skid dropped, drop_cnt=1. On out_ready=1, 0x55 is delivered once.
5. SKID=0, out_ready=0 with main valid -> in_ready=0. Same cycle out_ready=1 and in_valid=1 with 0x7 -> in_ready=1, 0x7 appears next cycle.
6. Reset mid-operation with occupancy=2 and squash=1 -> next cycle all outputs 0, drop_cnt=0. in_ready is 0 during rst and 1 the cycle after.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with optional skid entry,
// squash (optionally holding a stalled main entry) and a drop counter.
module pipe_stage_elastic #(
  parameter int unsigned WIDTH         = 256,
  parameter bit          SKID          = 1'b1,
  parameter bit          HOLD_ON_STALL = 1'b0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             squash,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_drop_nxt;
  logic [CNT_W:0]   w_sum;
  logic [1:0]       w_ndrop;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_hold;
  logic             w_main_lost;
  logic             w_skid_lost;

  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;
  assign drop_cnt  = r_drop;

  // Skid mode: ready depends on registered state only.
  assign in_ready = ~rst & (SKID ? (r_state != S_TWO)
                                 : (~out_valid | out_ready));

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    w_hold      = 1'b0;
    w_main_lost = 1'b0;
    w_skid_lost = 1'b0;
    if (squash) begin
      w_hold      = HOLD_ON_STALL & out_valid & ~out_ready;
      w_skid_lost = (r_state == S_TWO);
      w_main_lost = out_valid & ~w_out_fire & ~w_hold;
      w_skid_nxt  = '0;
      if (w_hold) begin
        w_state_nxt = S_ONE;
      end else begin
        w_state_nxt = S_EMPTY;
        w_main_nxt  = '0;
      end
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire && SKID) begin
            w_skid_nxt  = in_data;
            w_state_nxt = S_TWO;
          end else if (w_out_fire) begin
            w_main_nxt  = '0;
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
            w_state_nxt = S_ONE;
          end
        end
        default: begin
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Saturating add of entries lost to squash.
  always_comb begin
    w_ndrop    = {1'b0, w_main_lost} + {1'b0, w_skid_lost};
    w_sum      = (CNT_W+1)'(r_drop) + (CNT_W+1)'(w_ndrop);
    w_drop_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid/hold/single-entry variants,
// streaming, backpressure, squash, drop saturation and reset.
module tb_pipe_stage_elastic;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: SKID=1 HOLD=0 CNT_W=2 ; B: SKID=1 HOLD=1 ; C: SKID=0
  logic         a_iv = 0, a_ir, a_ov, a_or = 0, a_sq = 0;
  logic [W-1:0] a_id = '0, a_od;
  logic [1:0]   a_occ;
  logic [1:0]   a_dc;
  logic         b_iv = 0, b_ir, b_ov, b_or = 0, b_sq = 0;
  logic [W-1:0] b_id = '0, b_od;
  logic [1:0]   b_occ;
  logic [15:0]  b_dc;
  logic         c_iv = 0, c_ir, c_ov, c_or = 0, c_sq = 0;
  logic [W-1:0] c_id = '0, c_od;
  logic [1:0]   c_occ;
  logic [15:0]  c_dc;

  pipe_stage_elastic #(.WIDTH(W), .SKID(1'b1), .HOLD_ON_STALL(1'b0),
                       .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .squash(a_sq), .occupancy(a_occ),
    .drop_cnt(a_dc));

  pipe_stage_elastic #(.WIDTH(W), .SKID(1'b1), .HOLD_ON_STALL(1'b1),
                       .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .squash(b_sq), .occupancy(b_occ),
    .drop_cnt(b_dc));

  pipe_stage_elastic #(.WIDTH(W), .SKID(1'b0), .HOLD_ON_STALL(1'b0),
                       .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .squash(c_sq), .occupancy(c_occ),
    .drop_cnt(c_dc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_ir !== 1'b0 || b_ir !== 1'b0 || c_ir !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready: got %b%b%b want 000", a_ir, b_ir, c_ir); end
    checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0 || c_ov !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b%b%b want 000", a_ov, b_ov, c_ov); end
    checks++; if (a_od !== '0 || a_occ !== 2'd0 || a_dc !== 2'd0) begin
      errors++; $display("FAIL rst_state_a: got data %h occ %0d drop %0d want 0 0 0", a_od, a_occ, a_dc); end
    checks++; if (b_od !== '0 || b_occ !== 2'd0 || b_dc !== 16'd0) begin
      errors++; $display("FAIL rst_state_b: got data %h occ %0d drop %0d want 0 0 0", b_od, b_occ, b_dc); end
    rst = 1'b0;
    #1;
    checks++; if (a_ir !== 1'b1 || b_ir !== 1'b1 || c_ir !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready: got %b%b%b want 111", a_ir, b_ir, c_ir); end
  endtask

  task automatic test_streaming();
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1;
      a_id = W'(i);
      #1;
      checks++; if (a_ir !== 1'b1) begin
        errors++; $display("FAIL stream_ready_%0d: got %b want 1", i, a_ir); end
      tick();
      checks++; if (a_ov !== 1'b1 || a_od !== W'(i) || a_occ !== 2'd1) begin
        errors++; $display("FAIL stream_out_%0d: got v%b d%h occ%0d want v1 d%h occ1", i, a_ov, a_od, a_occ, W'(i)); end
    end
    a_iv = 1'b0;
    a_id = '0;
    tick();
    checks++; if (a_ov !== 1'b0 || a_od !== '0 || a_occ !== 2'd0) begin
      errors++; $display("FAIL stream_drain: got v%b d%h occ%0d want v0 d0 occ0", a_ov, a_od, a_occ); end
  endtask

  task automatic test_backpressure();
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = 16'h000A;
    tick();
    a_id = 16'h000B;
    tick();
    checks++; if (a_occ !== 2'd2 || a_ir !== 1'b0 || a_od !== 16'h000A) begin
      errors++; $display("FAIL bp_full: got occ%0d rdy%b d%h want occ2 rdy0 d000a", a_occ, a_ir, a_od); end
    a_id = 16'h000C;
    tick();
    checks++; if (a_occ !== 2'd2 || a_od !== 16'h000A) begin
      errors++; $display("FAIL bp_hold: got occ%0d d%h want occ2 d000a", a_occ, a_od); end
    a_or = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b0) begin
      errors++; $display("FAIL bp_ready_registered: got %b want 0", a_ir); end
    tick();
    checks++; if (a_od !== 16'h000B || a_occ !== 2'd1 || a_ir !== 1'b1) begin
      errors++; $display("FAIL bp_second: got d%h occ%0d rdy%b want d000b occ1 rdy1", a_od, a_occ, a_ir); end
    tick();
    checks++; if (a_od !== 16'h000C || a_ov !== 1'b1) begin
      errors++; $display("FAIL bp_third: got d%h v%b want d000c v1", a_od, a_ov); end
    a_iv = 1'b0;
    tick();
    checks++; if (a_ov !== 1'b0 || a_occ !== 2'd0) begin
      errors++; $display("FAIL bp_empty: got v%b occ%0d want v0 occ0", a_ov, a_occ); end
  endtask

  task automatic test_squash_drop();
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = 16'h0011;
    tick();
    a_id = 16'h0022;
    tick();
    a_sq = 1'b1;
    a_id = 16'h0033;
    tick();
    a_sq = 1'b0;
    a_iv = 1'b0;
    checks++; if (a_ov !== 1'b0 || a_od !== '0 || a_occ !== 2'd0 || a_dc !== 2'd2) begin
      errors++; $display("FAIL sq_clear: got v%b d%h occ%0d drop%0d want v0 d0 occ0 drop2", a_ov, a_od, a_occ, a_dc); end
    a_or = 1'b1;
    tick();
    checks++; if (a_ov !== 1'b0) begin
      errors++; $display("FAIL sq_beat_absent: got v%b d%h want v0", a_ov, a_od); end
    a_sq = 1'b1;
    tick();
    a_sq = 1'b0;
    checks++; if (a_dc !== 2'd2) begin
      errors++; $display("FAIL sq_empty_noop: got drop%0d want 2", a_dc); end
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = 16'h0044;
    tick();
    a_id = 16'h0045;
    tick();
    a_iv = 1'b0;
    a_sq = 1'b1;
    tick();
    a_sq = 1'b0;
    checks++; if (a_dc !== 2'd3 || a_occ !== 2'd0) begin
      errors++; $display("FAIL sq_saturate: got drop%0d occ%0d want drop3 occ0", a_dc, a_occ); end
    a_iv = 1'b1;
    a_id = 16'h0046;
    tick();
    a_iv = 1'b0;
    a_sq = 1'b1;
    tick();
    a_sq = 1'b0;
    checks++; if (a_dc !== 2'd3) begin
      errors++; $display("FAIL sq_sat_hold: got drop%0d want 3", a_dc); end
  endtask

  task automatic test_hold_on_stall();
    b_or = 1'b0;
    b_iv = 1'b1;
    b_id = 16'h0055;
    tick();
    b_id = 16'h0066;
    tick();
    b_sq = 1'b1;
    b_id = 16'h0077;
    tick();
    b_sq = 1'b0;
    b_iv = 1'b0;
    checks++; if (b_ov !== 1'b1 || b_od !== 16'h0055 || b_occ !== 2'd1 || b_dc !== 16'd1) begin
      errors++; $display("FAIL hold_keep: got v%b d%h occ%0d drop%0d want v1 d0055 occ1 drop1", b_ov, b_od, b_occ, b_dc); end
    b_or = 1'b1;
    tick();
    checks++; if (b_ov !== 1'b0 || b_occ !== 2'd0) begin
      errors++; $display("FAIL hold_drain: got v%b occ%0d want v0 occ0", b_ov, b_occ); end
    tick();
    checks++; if (b_ov !== 1'b0 || b_od !== '0) begin
      errors++; $display("FAIL hold_once: got v%b d%h want v0 d0", b_ov, b_od); end
    b_or = 1'b0;
    b_iv = 1'b1;
    b_id = 16'h0081;
    tick();
    b_id = 16'h0082;
    tick();
    b_iv = 1'b0;
    b_or = 1'b1;
    b_sq = 1'b1;
    tick();
    b_sq = 1'b0;
    checks++; if (b_ov !== 1'b0 || b_occ !== 2'd0 || b_dc !== 16'd2) begin
      errors++; $display("FAIL hold_fire_sq: got v%b occ%0d drop%0d want v0 occ0 drop2", b_ov, b_occ, b_dc); end
  endtask

  task automatic test_single_entry();
    c_or = 1'b0;
    c_iv = 1'b1;
    c_id = 16'h0005;
    #1;
    checks++; if (c_ir !== 1'b1) begin
      errors++; $display("FAIL s0_ready_empty: got %b want 1", c_ir); end
    tick();
    c_id = 16'h0007;
    #1;
    checks++; if (c_ir !== 1'b0 || c_occ !== 2'd1 || c_od !== 16'h0005) begin
      errors++; $display("FAIL s0_stall: got rdy%b occ%0d d%h want rdy0 occ1 d0005", c_ir, c_occ, c_od); end
    c_or = 1'b1;
    #1;
    checks++; if (c_ir !== 1'b1) begin
      errors++; $display("FAIL s0_ready_comb: got %b want 1", c_ir); end
    tick();
    checks++; if (c_ov !== 1'b1 || c_od !== 16'h0007 || c_occ !== 2'd1) begin
      errors++; $display("FAIL s0_next: got v%b d%h occ%0d want v1 d0007 occ1", c_ov, c_od, c_occ); end
    c_iv = 1'b0;
    tick();
    checks++; if (c_ov !== 1'b0 || c_occ !== 2'd0 || c_dc !== 16'd0) begin
      errors++; $display("FAIL s0_empty: got v%b occ%0d drop%0d want v0 occ0 drop0", c_ov, c_occ, c_dc); end
  endtask

  task automatic test_reset_mid();
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = 16'h0091;
    tick();
    a_id = 16'h0092;
    tick();
    checks++; if (a_occ !== 2'd2) begin
      errors++; $display("FAIL rmid_fill: got occ%0d want 2", a_occ); end
    rst = 1'b1;
    a_sq = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b0) begin
      errors++; $display("FAIL rmid_ready_rst: got %b want 0", a_ir); end
    tick();
    checks++; if (a_ov !== 1'b0 || a_od !== '0 || a_occ !== 2'd0 || a_dc !== 2'd0) begin
      errors++; $display("FAIL rmid_clear: got v%b d%h occ%0d drop%0d want all 0", a_ov, a_od, a_occ, a_dc); end
    rst = 1'b0;
    a_sq = 1'b0;
    a_iv = 1'b0;
    #1;
    checks++; if (a_ir !== 1'b1) begin
      errors++; $display("FAIL rmid_ready_after: got %b want 1", a_ir); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_squash_drop();
    test_hold_on_stall();
    test_single_entry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
